fetch_line_queue: RTL and testbench

- Parametrised successor to the fixed two-latch fetch buffer and packet extractor.
- Holds DEPTH instruction-cache lines in a circular queue and tracks a byte pointer into the head line.
- Presents a PKT_BYTES-wide instruction window to decode and retires bytes by the decoded instruction length.
- Sits between the fetch_1 line outputs and decode; resteer/branch flushes it with a new starting byte offset.

---
 rtl/fetchq_defs.sv | 21 ++
 rtl/fetchq_window_extract.sv | 32 +++
 rtl/fetch_line_queue.sv | 157 +++++++++++++++
 tb/tb_fetch_line_queue.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fetchq_defs.sv
// fetch_line_queue shared definitions.
// Default geometry, derived widths and the stats saturation helper.
package fetchq_defs;

  localparam int LINE_BYTES_DEF = 16;
  localparam int PKT_BYTES_DEF  = 16;
  localparam int DEPTH_DEF      = 4;
  localparam int LEN_W_DEF      = 8;

  localparam int OFF_W = $clog2(LINE_BYTES_DEF);
  localparam int CNT_W = $clog2(DEPTH_DEF) + 1;

  localparam logic [31:0] STAT_SAT = '1;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v
  );
    return (v == STAT_SAT) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetchq_window_extract.sv
// Two-slot byte rotator: picks PKT_BYTES bytes starting at offset
// from the concatenation {hi_line, lo_line}.
module fetchq_window_extract
  import fetchq_defs::*;
#(
  parameter int LINE_BYTES = LINE_BYTES_DEF,
  parameter int PKT_BYTES  = PKT_BYTES_DEF
) (
  input  logic [LINE_BYTES*8-1:0]         lo_line,
  input  logic [LINE_BYTES*8-1:0]         hi_line,
  input  logic [$clog2(LINE_BYTES)-1:0]   offset,
  output logic [PKT_BYTES*8-1:0]          window
);

  localparam int OW = $clog2(LINE_BYTES);
  localparam int SW = OW + 1;

  logic [2*LINE_BYTES*8-1:0] pair;
  logic [SW-1:0]             idx;

  // byte i of the window is byte (offset+i) of the two-line pair
  always_comb begin
    pair   = {hi_line, lo_line};
    idx    = '0;
    window = '0;
    for (int i = 0; i < PKT_BYTES; i++) begin
      idx = {1'b0, offset} + SW'(i);
      window[8*i +: 8] = pair[{idx, 3'b000} +: 8];
    end
  end

endmodule

// File: rtl/fetch_line_queue.sv
// Circular queue of fetched cache lines with a byte pointer feeding decode.
// Optional FETCHQ_STATS_EN adds saturating stall/starve counters.
module fetch_line_queue
  import fetchq_defs::*;
#(
  parameter int LINE_BYTES = LINE_BYTES_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int PKT_BYTES  = PKT_BYTES_DEF,
  parameter int LEN_W      = LEN_W_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic [$clog2(LINE_BYTES)-1:0]   flush_offset,
  input  logic [LINE_BYTES*8-1:0]         line_in,
  input  logic                            line_valid,
  output logic                            line_ready,
  input  logic [LEN_W-1:0]                D_length,
  input  logic                            stall,
  output logic [PKT_BYTES*8-1:0]          packet_out,
  output logic                            packet_valid,
  output logic [$clog2(LINE_BYTES)-1:0]   byte_ptr,
  output logic [$clog2(DEPTH):0]          occupancy,
  output logic                            len_err
`ifdef FETCHQ_STATS_EN
  ,
  output logic [31:0]                     stat_stall_cycles,
  output logic [31:0]                     stat_starve_cycles
`endif
);

  localparam int OW   = $clog2(LINE_BYTES);
  localparam int IW   = $clog2(DEPTH);
  localparam int CW   = IW + 1;
  localparam int SW   = OW + 1;
  localparam int AW   = CW + OW + 1;
  localparam int LB8  = LINE_BYTES * 8;
  localparam int PB8  = PKT_BYTES * 8;

  logic [LB8-1:0] slot_q [DEPTH];
  logic [LB8-1:0] slot_d [DEPTH];
  logic [IW-1:0]  head_q, head_d, tail_q, tail_d, head_nx;
  logic [CW-1:0]  count_q, count_d;
  logic [OW-1:0]  off_q, off_d;
  logic           err_q, err_d;

  logic [AW-1:0]  cap, need;
  logic           pkt_vld, push, pop, retire, over;
  logic [SW-1:0]  len, sum;
  logic [PB8-1:0] win;

  // bytes held versus bytes needed for a full window
  always_comb begin
    cap     = AW'(count_q) << OW;
    need    = AW'(off_q) + AW'(PKT_BYTES);
    pkt_vld = (cap >= need);
    head_nx = head_q + IW'(1);
  end

  fetchq_window_extract #(
    .LINE_BYTES (LINE_BYTES),
    .PKT_BYTES  (PKT_BYTES)
  ) u_extract (
    .lo_line (slot_q[head_q]),
    .hi_line (slot_q[head_nx]),
    .offset  (off_q),
    .window  (win)
  );

  // consume/push bookkeeping; flush overrides both
  always_comb begin
    over    = (D_length > LEN_W'(PKT_BYTES));
    len     = over ? SW'(PKT_BYTES) : SW'(D_length);
    pop     = pkt_vld & ~stall & (D_length != '0);
    sum     = SW'(off_q) + len;
    retire  = pop & sum[OW];
    push    = line_valid & line_ready & ~flush;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    off_d   = off_q;
    err_d   = err_q | (pop & over);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      off_d   = flush_offset;
    end else begin
      if (push) tail_d = tail_q + IW'(1);
      if (pop) off_d = sum[OW-1:0];
      if (retire) head_d = head_nx;
      count_d = count_q + CW'(push) - CW'(retire);
    end
  end

  // line storage write port
  always_comb begin
    slot_d = slot_q;
    if (push) slot_d[tail_q] = line_in;
  end

  // control state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      off_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      off_q   <= off_d;
      err_q   <= err_d;
    end
  end

  // line data needs no reset: it is masked until valid
  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

  assign line_ready   = (count_q != CW'(DEPTH));
  assign packet_valid = pkt_vld;
  assign packet_out   = pkt_vld ? win : '0;
  assign byte_ptr     = off_q;
  assign occupancy    = count_q;
  assign len_err      = err_q;

`ifdef FETCHQ_STATS_EN
  logic [31:0] stall_q, stall_d, starve_q, starve_d;

  // saturating event counters, untouched by flush
  always_comb begin
    stall_d  = stall_q;
    starve_d = starve_q;
    if (pkt_vld & stall) stall_d = sat_inc(stall_q);
    if (~pkt_vld & ~flush) starve_d = sat_inc(starve_q);
  end

  // stats registers
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q  <= '0;
      starve_q <= '0;
    end else begin
      stall_q  <= stall_d;
      starve_q <= starve_d;
    end
  end

  assign stat_stall_cycles  = stall_q;
  assign stat_starve_cycles = starve_q;
`endif

endmodule

// File: tb/tb_fetch_line_queue.sv
// Directed bench for fetch_line_queue with hand-computed windows.
// Lines use ascending byte values so windows are simple sequences.
module tb_fetch_line_queue;

  logic         clk = 1'b0;
  logic         reset, flush, line_valid, stall;
  logic [3:0]   flush_offset;
  logic [127:0] line_in;
  logic         line_ready, packet_valid, len_err;
  logic [7:0]   D_length;
  logic [127:0] packet_out;
  logic [3:0]   byte_ptr;
  logic [2:0]   occupancy;
`ifdef FETCHQ_STATS_EN
  logic [31:0]  stat_stall_cycles, stat_starve_cycles;
`endif

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_line_queue dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .flush_offset (flush_offset),
    .line_in      (line_in),
    .line_valid   (line_valid),
    .line_ready   (line_ready),
    .D_length     (D_length),
    .stall        (stall),
    .packet_out   (packet_out),
    .packet_valid (packet_valid),
    .byte_ptr     (byte_ptr),
    .occupancy    (occupancy),
    .len_err      (len_err)
`ifdef FETCHQ_STATS_EN
    ,
    .stat_stall_cycles  (stat_stall_cycles),
    .stat_starve_cycles (stat_starve_cycles)
`endif
  );

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] seq(input int start);
    logic [127:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) w[8*i +: 8] = 8'(start + i);
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int base);
    line_in    = seq(base);
    line_valid = 1'b1;
    tick();
    line_valid = 1'b0;
  endtask

  task automatic consume(input int n);
    D_length = 8'(n);
    tick();
    D_length = '0;
  endtask

  initial begin
    reset        = 1'b1;
    flush        = 1'b0;
    flush_offset = '0;
    line_in      = '0;
    line_valid   = 1'b0;
    D_length     = '0;
    stall        = 1'b0;
    tick();
    reset = 1'b0;
    check("rst_pv",   packet_valid, 0);
    check("rst_pkt",  packet_out,   0);
    check("rst_ptr",  byte_ptr,     0);
    check("rst_occ",  occupancy,    0);
    check("rst_rdy",  line_ready,   1);
    check("rst_err",  len_err,      0);

    push(8'h00);
    check("a_pv",  packet_valid, 1);
    check("a_pkt", packet_out,   seq(8'h00));
    check("a_occ", occupancy,    1);

    push(8'h10);
    check("b_occ", occupancy, 2);
    consume(3);
    check("c3_ptr", byte_ptr,   3);
    check("c3_pkt", packet_out, seq(8'h03));
    consume(5);
    check("c5_ptr", byte_ptr,   8);
    check("c5_pkt", packet_out, seq(8'h08));
    line_in    = seq(8'h20);
    line_valid = 1'b1;
    consume(9);
    line_valid = 1'b0;
    check("c9_ptr", byte_ptr,   1);
    check("c9_occ", occupancy,  2);
    check("c9_pkt", packet_out, seq(8'h11));
    tick();
    check("hold_ptr", byte_ptr, 1);

    push(8'h30);
    push(8'h40);
    check("full_occ", occupancy,  4);
    check("full_rdy", line_ready, 0);
    line_in    = seq(8'h50);
    line_valid = 1'b1;
    tick();
    check("ign_occ", occupancy, 4);
    consume(15);
    line_valid = 1'b0;
    check("pop_occ", occupancy,  3);
    check("pop_rdy", line_ready, 1);
    check("pop_ptr", byte_ptr,   0);
    check("pop_pkt", packet_out, seq(8'h20));

    push(8'h50);
    check("f_occ", occupancy, 4);
    consume(16);
    check("c16_pkt", packet_out, seq(8'h30));
    check("c16_occ", occupancy,  3);
    consume(4);
    check("wrap_pkt", packet_out, seq(8'h34));
    push(8'h60);
    check("g_rdy", line_ready, 0);

    flush        = 1'b1;
    flush_offset = 4'd6;
    line_in      = seq(8'h70);
    line_valid   = 1'b1;
    tick();
    flush      = 1'b0;
    line_valid = 1'b0;
    check("fl_occ", occupancy,    0);
    check("fl_ptr", byte_ptr,     6);
    check("fl_pv",  packet_valid, 0);
    check("fl_rdy", line_ready,   1);
    push(8'h20);
    check("fc_occ", occupancy,    1);
    check("fc_pv",  packet_valid, 0);
    check("fc_pkt", packet_out,   0);
    push(8'h30);
    check("fd_pv",  packet_valid, 1);
    check("fd_pkt", packet_out,   seq(8'h26));

    stall    = 1'b1;
    D_length = 8'd4;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_ptr", byte_ptr, 6);
    end
`ifdef FETCHQ_STATS_EN
    check("stat_stall", stat_stall_cycles, 3);
`endif
    stall = 1'b0;
    consume(20);
    check("big_err", len_err,      1);
    check("big_ptr", byte_ptr,     6);
    check("big_occ", occupancy,    1);
    check("big_pv",  packet_valid, 0);
    tick();
    check("err_stk", len_err, 1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rr_err", len_err,   0);
    check("rr_occ", occupancy, 0);
    check("rr_ptr", byte_ptr,  0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
